// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-issue instruction fetch controller.
// Requests one instruction word at a time from instruction memory, holds it
// for the decoder, and handles trap, redirect, halt and misaligned-target
// events. An instruction retires when the decoder accepts it.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   run                   start fetching from IDLE
//   imem_req/imem_addr    memory request (FETCH only) and fetch address (= pc)
//   imem_ack/imem_rdata   memory response, data valid in the ack cycle
//   instr_valid/instr/instr_pc  held instruction presented to the decoder
//   dec_ready             decoder accepts the held instruction
//   redirect/redirect_pc  taken branch/jump and its target
//   trap                  exception request, vectors to TRAP_VEC
//   halt_req/halted       stop at the next instruction boundary / in HALT
//   misalign              one-cycle pulse on a misaligned redirect
//   instr_count           retired instruction counter (wraps)
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        dec_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        trap,
  input  logic        halt_req,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] instr_count
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            retire;
  logic            bad_target;

  // Decoded from registers only, no input feeds these outputs.
  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);

  // The held instruction is retired whenever the decoder takes it, even if a
  // trap or redirect flushes the pipeline in the same cycle.
  assign retire     = (state == ST_HOLD) && dec_ready;
  assign bad_target = (redirect_pc[1:0] != 2'b00);

  // State, pc and held-instruction registers; events ordered trap > redirect > halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      instr_count <= '0;
      misalign    <= 1'b0;
    end else begin
      misalign <= 1'b0;
      if (state != ST_HALT) begin
        if (retire) instr_count <= instr_count + XLEN'(1);

        if (trap || redirect) begin
          // A misaligned redirect is treated as a trap; a same-cycle ack is dropped.
          if (trap || bad_target) begin
            pc       <= TRAP_VEC;
            misalign <= ~trap;
          end else begin
            pc <= redirect_pc;
          end
          instr_valid <= 1'b0;
          if (state != ST_IDLE) state <= ST_FETCH;
        end else if (halt_req && ((state == ST_IDLE) || retire)) begin
          instr_valid <= 1'b0;
          state       <= ST_HALT;
        end else begin
          case (state)
            ST_IDLE: begin
              if (run) state <= ST_FETCH;
            end
            ST_FETCH: begin
              if (imem_ack) begin
                instr       <= imem_rdata;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + XLEN'(4);
                state       <= ST_HOLD;
              end
            end
            ST_HOLD: begin
              if (dec_ready) begin
                instr_valid <= 1'b0;
                state       <= ST_FETCH;
              end
            end
            default: state <= ST_HALT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl. A driver issues directed and
// random stimulus, advances a behavioural model and queues the expected
// outputs; a monitor pops one expectation per clock and compares.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, run, imem_ack, dec_ready, redirect, trap, halt_req;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, instr_valid, halted, misalign;
  logic [31:0] imem_addr, instr, instr_pc, instr_count;

  fetch_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .dec_ready(dec_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .trap(trap), .halt_req(halt_req), .halted(halted),
    .misalign(misalign), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef enum int { M_IDLE, M_FETCH, M_HOLD, M_HALT } mode_t;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        halted;
    logic        valid;
    logic [31:0] word;
    logic [31:0] wpc;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t  expq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Behavioural model state.
  mode_t       m_mode = M_IDLE;
  logic [31:0] m_pc = '0, m_word = '0, m_wpc = '0, m_cnt = '0;
  logic        m_valid = 1'b0, m_mis = 1'b0;

  // One clock of the fetch rules applied to the inputs currently driven.
  task automatic model_step();
    bit took, flush, to_vec;
    if (rst) begin
      m_mode = M_IDLE; m_pc = RESET_PC; m_word = '0; m_wpc = '0;
      m_valid = 1'b0; m_cnt = '0; m_mis = 1'b0;
      return;
    end
    m_mis = 1'b0;
    if (m_mode == M_HALT) return;
    took  = (m_mode == M_HOLD) && dec_ready;
    flush = trap || redirect;
    if (took) m_cnt = m_cnt + 1;
    if (flush) begin
      to_vec  = trap || (redirect_pc % 4 != 0);
      m_pc    = to_vec ? TRAP_VEC : redirect_pc;
      m_mis   = !trap && (redirect_pc % 4 != 0);
      m_valid = 1'b0;
      if (m_mode != M_IDLE) m_mode = M_FETCH;
    end else if (halt_req && (m_mode == M_IDLE || took)) begin
      m_mode  = M_HALT;
      m_valid = 1'b0;
    end else if (m_mode == M_IDLE && run) begin
      m_mode = M_FETCH;
    end else if (m_mode == M_FETCH && imem_ack) begin
      m_word = imem_rdata; m_wpc = m_pc; m_valid = 1'b1;
      m_pc = m_pc + 4; m_mode = M_HOLD;
    end else if (took) begin
      m_valid = 1'b0; m_mode = M_FETCH;
    end
  endtask

  // Step the model, queue the expectation and let the DUT take the edge.
  task automatic tick();
    exp_t e;
    model_step();
    e.req = (m_mode == M_FETCH); e.addr = m_pc; e.halted = (m_mode == M_HALT);
    e.valid = m_valid; e.word = m_word; e.wpc = m_wpc; e.mis = m_mis; e.cnt = m_cnt;
    expq.push_back(e);
    @(negedge clk);
  endtask

  task automatic quiet();
    rst = 0; run = 0; imem_ack = 0; dec_ready = 0; redirect = 0; trap = 0;
    halt_req = 0; redirect_pc = '0; imem_rdata = '0;
  endtask

  // Address-tagged instruction word for the current fetch address.
  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares every DUT output cycle against the queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      chk("imem_req", 32'(imem_req), 32'(e.req));
      chk("imem_addr", imem_addr, e.addr);
      chk("halted", 32'(halted), 32'(e.halted));
      chk("instr_valid", 32'(instr_valid), 32'(e.valid));
      chk("misalign", 32'(misalign), 32'(e.mis));
      chk("instr_count", instr_count, e.cnt);
      if (e.valid) begin
        chk("instr", instr, e.word);
        chk("instr_pc", instr_pc, e.wpc);
      end
    end
  end

  // Drive run/ack until the model holds an instruction (bounded).
  task automatic to_hold();
    for (int i = 0; i < 8 && m_mode != M_HOLD; i++) begin
      quiet(); run = 1; imem_ack = 1; imem_rdata = tag(m_pc);
      tick();
    end
  endtask

  task automatic do_reset();
    quiet(); rst = 1; tick(); tick(); quiet();
  endtask

  initial begin
    logic [31:0] r;
    quiet();
    @(negedge clk);
    do_reset();

    // Sequential: ack and dec_ready tied high, 4 instructions retire.
    for (int i = 0; i < 9; i++) begin
      quiet(); run = 1; imem_ack = 1; dec_ready = 1; imem_rdata = tag(m_pc);
      tick();
    end

    // Stall: ack low 3 cycles, then decoder stalls 2 cycles.
    for (int i = 0; i < 3; i++) begin quiet(); tick(); end
    quiet(); imem_ack = 1; imem_rdata = tag(m_pc); tick();
    for (int i = 0; i < 2; i++) begin quiet(); tick(); end
    quiet(); dec_ready = 1; tick();

    // Redirect aligned in HOLD, then misaligned in HOLD.
    to_hold();
    quiet(); redirect = 1; redirect_pc = 32'h0000_0040; tick();
    to_hold();
    quiet(); redirect = 1; redirect_pc = 32'h0000_0042; tick();
    quiet(); tick();

    // Priority: trap + redirect + ack in the same FETCH cycle.
    quiet(); trap = 1; redirect = 1; redirect_pc = 32'h0000_0080;
    imem_ack = 1; imem_rdata = 32'hBAD0_BAD0; tick();
    quiet(); redirect = 1; redirect_pc = 32'h0000_0200; imem_ack = 1; imem_rdata = 32'hBAD1_BAD1; tick();

    // Wrap: redirect to the top word, fetch it, next address is 0.
    quiet(); redirect = 1; redirect_pc = 32'hFFFF_FFFC; tick();
    quiet(); imem_ack = 1; imem_rdata = tag(m_pc); tick();
    quiet(); dec_ready = 1; tick();

    // Halt: requested during FETCH, completes to HOLD, halts on accept.
    quiet(); halt_req = 1; tick();
    quiet(); halt_req = 1; imem_ack = 1; imem_rdata = tag(m_pc); tick();
    quiet(); halt_req = 1; dec_ready = 1; tick();
    for (int i = 0; i < 4; i++) begin
      quiet(); run = 1; trap = (i % 2 == 0); redirect = (i % 2 == 1);
      redirect_pc = 32'h0000_0300; imem_ack = 1; dec_ready = 1; tick();
    end

    // Reset mid-operation in HOLD, and reset with a same-cycle ack.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      quiet(); run = 1; imem_ack = 1; dec_ready = 1; imem_rdata = tag(m_pc); tick();
    end
    to_hold();
    quiet(); rst = 1; dec_ready = 1; tick();
    quiet(); run = 1; tick();
    quiet(); rst = 1; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; tick();
    quiet(); tick();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      quiet();
      rst       = ($urandom_range(0, 63) == 0);
      run       = 1'($urandom_range(0, 1));
      imem_ack  = 1'($urandom_range(0, 1));
      dec_ready = 1'($urandom_range(0, 1));
      redirect  = ($urandom_range(0, 7) == 0);
      trap      = ($urandom_range(0, 15) == 0);
      halt_req  = ($urandom_range(0, 23) == 0);
      r = $urandom();
      redirect_pc = ($urandom_range(0, 1) == 0) ? {r[31:2], 2'b00} : r;
      imem_rdata  = $urandom();
      tick();
    end

    quiet();
    @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL timeout: run did not complete, got time %0t expected below 200000", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded by reset.
REQ-002 Parameter TRAP_VEC, default 32'h0000_0100: PC target for traps and misaligned redirects.
REQ-003 Port list, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  start fetching from IDLE.
- imem_req  output  1  instruction-memory request, high only in FETCH.
- imem_addr  output  32  fetch address, equal to the internal pc register.
- imem_ack  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr_valid  output  1  instr/instr_pc hold a valid instruction.
- instr  output  32  held instruction word.
- instr_pc  output  32  address of the held instruction.
- dec_ready  input  1  decoder accepts the held instruction.
- redirect  input  1  branch/jump taken.
- redirect_pc  input  32  branch/jump target.
- trap  input  1  exception request.
- halt_req  input  1  stop at the next instruction boundary.
- halted  output  1  block is in HALT.
- misalign  output  1  one-cycle pulse on a misaligned redirect.
- instr_count  output  32  number of retired (accepted) instructions.

Function
REQ-004 States: IDLE, FETCH, HOLD, HALT; state, pc, instr, instr_pc, instr_valid and instr_count are registered.
REQ-005 imem_req = (state==FETCH); imem_addr = pc; halted = (state==HALT); all three are decoded from registers, with no input-to-output combinational path.
REQ-006 IDLE: run=1 -> FETCH; otherwise remain in IDLE.
REQ-007 FETCH with imem_ack=1: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, then HOLD; ack to instr_valid latency is 1 cycle.
REQ-008 FETCH with imem_ack=0: remain in FETCH with pc unchanged; imem_req stays high.
REQ-009 HOLD: instr_valid=1 and imem_req=0.
- dec_ready=1 -> instr_valid<=0, instr_count<=instr_count+1, then FETCH.
- dec_ready=0 -> hold all outputs stable.
REQ-010 Throughput: with imem_ack and dec_ready tied high, one instruction every 2 cycles.
REQ-011 pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000. instr_count wraps from 32'hFFFF_FFFF to 0.
REQ-012 Event priority: rst > trap > redirect > halt_req > normal operation.
REQ-013 trap in FETCH or HOLD: pc<=TRAP_VEC, instr_valid<=0, then FETCH. A same-cycle imem_ack is discarded; dec_ready still counts a HOLD instruction as retired.
REQ-014 redirect in FETCH or HOLD with redirect_pc[1:0]==0: pc<=redirect_pc, instr_valid<=0, then FETCH, with the same ack-discard and retire rule as REQ-013.
REQ-015 redirect with redirect_pc[1:0]!=0: behave as trap (pc<=TRAP_VEC) and pulse misalign high for exactly one cycle.
REQ-016 trap or redirect in IDLE: update pc per REQ-013/014/015 and remain in IDLE.
REQ-017 trap and redirect are ignored in HALT.
REQ-018 halt_req is taken only at an instruction boundary.
- In IDLE -> HALT.
- In HOLD with dec_ready=1 -> HALT instead of FETCH.
- In FETCH, the outstanding request completes into HOLD first.
REQ-019 HALT is left only by rst; imem_req=0 and instr_valid=0 while in HALT.

Reset
REQ-020 On rst=1 at posedge, regardless of state or in-flight request:
- state<=IDLE, pc<=RESET_PC.
- instr<=0, instr_pc<=0, instr_valid<=0, instr_count<=0, misalign<=0.
REQ-021 rst during FETCH with a same-cycle imem_ack discards the data; the next cycle shows imem_req=0 and imem_addr=RESET_PC.

Verification
REQ-022 Bench shall cover these scenarios:
- Sequential: reset, run=1, imem_ack and dec_ready tied 1, imem_rdata=addr-tagged words -> instr_pc sequence 0,4,8,12 every 2 cycles; instr_count=4 after the 4th accept.
- Stall: imem_ack low 3 cycles in FETCH, then dec_ready low 2 cycles in HOLD -> imem_addr stable; instr/instr_pc stable while instr_valid=1; no extra count.
- Redirect: redirect=1, redirect_pc=32'h0000_0040 in HOLD -> next cycle instr_valid=0, imem_addr=32'h40. Redirect_pc=32'h42 -> imem_addr=32'h100 and a single-cycle misalign pulse.
- Priority: trap and redirect (pc=32'h80) in the same cycle as imem_ack -> imem_addr=32'h100; ack data never appears on instr.
- Wrap and halt: pc forced via redirect to 32'hFFFF_FFFC, ack -> next fetch addr 0. halt_req in FETCH -> HOLD, then HALT after dec_ready; halted=1; run/trap ignored until rst.
- Reset mid-operation: rst in HOLD -> instr_valid=0, instr_count=0, state IDLE, imem_addr=RESET_PC.
